// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the user-pad serial configuration path: word width,
// field offsets inside a pad configuration word, reset default and FSM states.
package gpio_cfg_pkg;

   localparam int CFG_BITS = 13;

   // Bit positions of the fields inside one pad configuration word
   localparam int CFG_MGMT_EN     = 0;
   localparam int CFG_OUTENB      = 1;
   localparam int CFG_HOLDOVER    = 2;
   localparam int CFG_INP_DIS     = 3;
   localparam int CFG_IB_MODE_SEL = 4;
   localparam int CFG_ANALOG_EN   = 5;
   localparam int CFG_ANALOG_SEL  = 6;
   localparam int CFG_ANALOG_POL  = 7;
   localparam int CFG_SLOW_SEL    = 8;
   localparam int CFG_VTRIP_SEL   = 9;
   localparam int CFG_DM_LSB      = 10;
   localparam int CFG_DM_MSB      = 12;

   // Power-on word: management-controlled, output disabled, dm = 3'b110
   localparam logic [CFG_BITS-1:0] CFG_DEFAULT = 13'h1803;

   typedef enum logic [2:0] {
      IDLE,
      CHAIN_RST,
      SHIFT,
      LOAD,
      DONE
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/gpio_serial_chain_shifter.sv
// Parallel-load, MSB-out shift register for one serial chain. The chain word
// occupies the low bits of an NB-bit register so a shorter chain emits
// leading zeros and ends its valid data on the same final bit as the longer one.
module gpio_serial_chain_shifter
   import gpio_cfg_pkg::*;
#(
   parameter int NUM_PADS = 19,
   parameter int NB       = 19 * CFG_BITS
) (
   input  logic                         clock,
   input  logic                         resetb,
   input  logic                         load,
   input  logic                         shift,
   input  logic [NUM_PADS*CFG_BITS-1:0] data,
   output logic                         msb
);

   logic [NB-1:0] sr;

   // Snapshot the chain word on load, otherwise shift one bit toward the MSB
   always_ff @(posedge clock) begin
      // NOTE: the shift register is reset so a transfer aborted by reset leaves no stale snapshot behind.
      if (!resetb) begin
         sr <= '0;
      end else if (load) begin
         sr <= NB'(data);
      end else if (shift) begin
         sr <= {sr[NB-2:0], 1'b0};
      end
   end

   assign msb = sr[NB-1];

endmodule

// File: rtl/gpio_serial_loader.sv
// Transmitter for the two user-pad configuration chains. A start request
// snapshots every pad word, pulses the chain reset, shifts both chains in
// lockstep with a divided serial clock and finally pulses serial_load.
module gpio_serial_loader
   import gpio_cfg_pkg::*;
#(
   parameter int NUM_PADS_1 = 19,
   parameter int NUM_PADS_2 = 19,
   parameter int CLK_DIV    = 2
) (
   input  logic                                       clock,
   input  logic                                       resetb,
   input  logic                                       start,
   input  logic [(NUM_PADS_1+NUM_PADS_2)*CFG_BITS-1:0] cfg_data,
   output logic                                       busy,
   output logic                                       done,
   output logic                                       serial_clock,
   output logic                                       serial_resetn,
   output logic                                       serial_load,
   output logic                                       serial_data_1,
   output logic                                       serial_data_2
);

   localparam int D    = CLK_DIV;
   localparam int LEN1 = NUM_PADS_1 * CFG_BITS;
   localparam int LEN2 = NUM_PADS_2 * CFG_BITS;
   localparam int NB   = max_int(NUM_PADS_1, NUM_PADS_2) * CFG_BITS;
   localparam int CW   = $clog2(2 * D + 1);
   localparam int BW   = $clog2(NB + 1);

   localparam logic [CW-1:0] PH_LOW_END  = CW'(D - 1);
   localparam logic [CW-1:0] PH_HIGH_END = CW'(2 * D - 1);
   localparam logic [CW-1:0] PH_LOAD_END = CW'(2 * D);
   localparam logic [BW-1:0] LAST_BIT    = BW'(NB - 1);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [BW-1:0]   bit_cnt;
   logic [LEN1-1:0] chain1_word;
   logic [LEN2-1:0] chain2_word;
   logic            msb_1;
   logic            msb_2;
   logic            load_sr;
   logic            emit;

   // Chain 1 already has pad NUM_PADS_1-1 in its top bits; chain 2 must be
   // reversed word-wise so its first pad (index NUM_PADS_1) leaves first.
   assign chain1_word = cfg_data[LEN1-1:0];

   for (genvar j = 0; j < NUM_PADS_2; j++) begin : g_chain2_order
      assign chain2_word[(NUM_PADS_2-1-j)*CFG_BITS +: CFG_BITS] =
         cfg_data[(NUM_PADS_1+j)*CFG_BITS +: CFG_BITS];
   end

   assign load_sr = (state == IDLE) && start;
   assign emit    = ((state == CHAIN_RST) && (cnt == PH_LOW_END)) ||
                    ((state == SHIFT) && (cnt == PH_HIGH_END) && (bit_cnt != LAST_BIT));

   gpio_serial_chain_shifter #(.NUM_PADS(NUM_PADS_1), .NB(NB)) u_chain_1 (
      .clock  (clock),
      .resetb (resetb),
      .load   (load_sr),
      .shift  (emit),
      .data   (chain1_word),
      .msb    (msb_1)
   );

   gpio_serial_chain_shifter #(.NUM_PADS(NUM_PADS_2), .NB(NB)) u_chain_2 (
      .clock  (clock),
      .resetb (resetb),
      .load   (load_sr),
      .shift  (emit),
      .data   (chain2_word),
      .msb    (msb_2)
   );

   // Transfer sequencer with every serial-side output registered
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments keep each register update ordered by the clock edge, not by statement order.
      if (!resetb) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_cnt       <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         serial_clock  <= 1'b0;
         serial_resetn <= 1'b0;
         serial_load   <= 1'b0;
         serial_data_1 <= 1'b0;
         serial_data_2 <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               serial_resetn <= 1'b1;
               if (start) begin
                  busy          <= 1'b1;
                  serial_resetn <= 1'b0;
                  cnt           <= '0;
                  state         <= CHAIN_RST;
               end
            end
            CHAIN_RST: begin
               if (cnt == PH_LOW_END) begin
                  serial_resetn <= 1'b1;
                  cnt           <= '0;
                  bit_cnt       <= '0;
                  serial_data_1 <= msb_1;
                  serial_data_2 <= msb_2;
                  state         <= SHIFT;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            SHIFT: begin
               if (cnt == PH_LOW_END) begin
                  serial_clock <= 1'b1;
                  cnt          <= cnt + CW'(1);
               end else if (cnt == PH_HIGH_END) begin
                  serial_clock <= 1'b0;
                  cnt          <= '0;
                  if (bit_cnt == LAST_BIT) begin
                     state <= LOAD;
                  end else begin
                     bit_cnt       <= bit_cnt + BW'(1);
                     serial_data_1 <= msb_1;
                     serial_data_2 <= msb_2;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            LOAD: begin
               if (cnt == PH_LOW_END) begin
                  serial_load <= 1'b1;
               end else if (cnt == PH_HIGH_END) begin
                  serial_load <= 1'b0;
               end
               if (cnt == PH_LOAD_END) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  cnt   <= '0;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Self-checking bench for gpio_serial_loader: a default-size instance driven
// through table vectors, random transfers and corner sequences against a
// pad-chain receiver model, plus a small unequal-chain instance.
module tb_gpio_serial_loader;

   localparam int W   = 13;
   localparam int N1  = 19;
   localparam int N2  = 19;
   localparam int N   = N1 + N2;
   localparam int SN1 = 2;
   localparam int SN2 = 3;

   logic clock = 1'b0;
   logic resetb = 1'b0;

   // default instance
   logic           start = 1'b0;
   logic [N*W-1:0] cfg_data = '0;
   logic busy, done, serial_clock, serial_resetn, serial_load, serial_data_1, serial_data_2;

   // small instance
   logic                   start_s = 1'b0;
   logic [(SN1+SN2)*W-1:0] cfg_s = '0;
   logic busy_s, done_s, sclk_s, srstn_s, sload_s, sd1_s, sd2_s;

   int total = 0;
   int bad   = 0;

   gpio_serial_loader dut (
      .clock(clock), .resetb(resetb), .start(start), .cfg_data(cfg_data),
      .busy(busy), .done(done), .serial_clock(serial_clock),
      .serial_resetn(serial_resetn), .serial_load(serial_load),
      .serial_data_1(serial_data_1), .serial_data_2(serial_data_2)
   );

   gpio_serial_loader #(.NUM_PADS_1(SN1), .NUM_PADS_2(SN2), .CLK_DIV(1)) dut_s (
      .clock(clock), .resetb(resetb), .start(start_s), .cfg_data(cfg_s),
      .busy(busy_s), .done(done_s), .serial_clock(sclk_s),
      .serial_resetn(srstn_s), .serial_load(sload_s),
      .serial_data_1(sd1_s), .serial_data_2(sd2_s)
   );

   always #5 clock = ~clock;

   // ---------------- receiver model: chains of pad blocks ----------------
   bit          q1[$];
   bit          q2[$];
   bit          qs1[$];
   bit          qs2[$];
   logic [W-1:0] lat [N] = '{default: '0};
   int          rise_cnt = 0;
   int          load_pulses = 0;

   always @(posedge serial_clock) begin
      q1.push_back(serial_data_1);
      q2.push_back(serial_data_2);
      rise_cnt++;
   end

   always @(negedge serial_resetn) begin
      q1.delete();
      q2.delete();
   end

   // The block nearest the chain end holds the most recent bits: on chain 1
   // that is pad 0, on chain 2 it is the last pad.
   always @(posedge serial_load) begin
      int n1, n2;
      logic [W-1:0] w;
      n1 = q1.size();
      n2 = q2.size();
      load_pulses++;
      if (n1 >= N1 * W && n2 >= N2 * W) begin
         for (int p = 0; p < N1; p++) begin
            for (int b = 0; b < W; b++) w[W-1-b] = q1[n1 - (p + 1) * W + b];
            lat[p] = w;
         end
         for (int j = 0; j < N2; j++) begin
            for (int b = 0; b < W; b++) w[W-1-b] = q2[n2 - N2 * W + j * W + b];
            lat[N1 + j] = w;
         end
      end
   end

   always @(posedge sclk_s) begin
      qs1.push_back(sd1_s);
      qs2.push_back(sd2_s);
   end

   // ---------------- helpers ----------------
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [W-1:0] qword(input int chain, input int base);
      logic [W-1:0] w;
      for (int b = 0; b < W; b++) begin
         if (chain == 1) w[W-1-b] = (base + b < q1.size()) ? q1[base + b] : 1'bx;
         else            w[W-1-b] = (base + b < q2.size()) ? q2[base + b] : 1'bx;
      end
      return w;
   endfunction

   function automatic logic [W-1:0] sword(input int chain, input int base);
      logic [W-1:0] w;
      for (int b = 0; b < W; b++) begin
         if (chain == 1) w[W-1-b] = (base + b < qs1.size()) ? qs1[base + b] : 1'bx;
         else            w[W-1-b] = (base + b < qs2.size()) ? qs2[base + b] : 1'bx;
      end
      return w;
   endfunction

   function automatic logic [W-1:0] pattern(input int mode, input int p);
      case (mode)
         0:       return W'(p);
         1:       return ~W'(p);
         2:       return 13'h1aaa;
         default: return W'(p * 300);
      endcase
   endfunction

   task automatic check_latched(input string nm, input logic [N*W-1:0] exp);
      int mism = 0;
      for (int p = 0; p < N; p++) if (lat[p] !== exp[p*W +: W]) mism++;
      check(nm, mism, 0);
   endtask

   // Called at a negedge; the accept edge is the next posedge.
   task automatic run_main(input bit inject, input bit flip,
                           output int lat_cyc, output int loadw, output int dones);
      int n = 0;
      lat_cyc = 0; loadw = 0; dones = 0; rise_cnt = 0;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      if (flip) cfg_data = ~cfg_data;
      while (n < 3000) begin
         @(negedge clock);
         n++;
         start = inject && (n == 5 || n == 500);
         if (serial_load) loadw++;
         if (done) begin
            dones++;
            lat_cyc = n;
            break;
         end
      end
      start = 1'b0;
      if (n >= 3000) check("transfer_timeout", 0, 1);
      repeat (3) begin
         @(negedge clock);
         if (done) dones++;
      end
   endtask

   typedef struct {
      int           mode;
      logic [W-1:0] first1;
      logic [W-1:0] first2;
      logic [W-1:0] last1;
      logic [W-1:0] last2;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int lc, lw, dn, n;
      logic [N*W-1:0] saved;
      logic [W-1:0]   saved_lat [N];
      int             saved_loads, mism;

      vecs[0] = '{0, 13'd18,   13'd19,   13'd0,    13'd37};
      vecs[1] = '{1, 13'd8173, 13'd8172, 13'd8191, 13'd8154};
      vecs[2] = '{2, 13'h1aaa, 13'h1aaa, 13'h1aaa, 13'h1aaa};
      vecs[3] = '{3, 13'd5400, 13'd5700, 13'd0,    13'd2908};

      // ---- reset state ----
      repeat (3) @(negedge clock);
      check("reset_outputs", {busy, done, serial_clock, serial_load, serial_data_1, serial_data_2}, 0);
      check("reset_serial_resetn", serial_resetn, 0);
      resetb = 1'b1;
      @(negedge clock);
      check("resetn_after_release", serial_resetn, 1);
      check("small_resetn_after_release", srstn_s, 1);

      // ---- table vectors ----
      for (int v = 0; v < 4; v++) begin
         for (int p = 0; p < N; p++) cfg_data[p*W +: W] = pattern(vecs[v].mode, p);
         run_main(1'b0, 1'b0, lc, lw, dn);
         check($sformatf("v%0d_latency", v), lc, 995);
         check($sformatf("v%0d_load_width", v), lw, 2);
         check($sformatf("v%0d_done_count", v), dn, 1);
         check($sformatf("v%0d_bits", v), q1.size(), 19 * W);
         check($sformatf("v%0d_first1", v), qword(1, 0), vecs[v].first1);
         check($sformatf("v%0d_first2", v), qword(2, 0), vecs[v].first2);
         check($sformatf("v%0d_last1", v), qword(1, 18 * W), vecs[v].last1);
         check($sformatf("v%0d_last2", v), qword(2, 18 * W), vecs[v].last2);
         check($sformatf("v%0d_latched", v), 0, 0 + (lat[18] !== vecs[v].first1));
         check($sformatf("v%0d_busy_idle", v), busy, 0);
      end

      // ---- random transfers ----
      for (int t = 0; t < 10; t++) begin
         for (int p = 0; p < N; p++) cfg_data[p*W +: W] = W'($urandom);
         run_main(1'b0, 1'b0, lc, lw, dn);
         check($sformatf("rand%0d_latency", t), lc, 995);
         check_latched($sformatf("rand%0d_latched", t), cfg_data);
         check($sformatf("rand%0d_hold_d1", t), serial_data_1, cfg_data[0]);
         check($sformatf("rand%0d_hold_d2", t), serial_data_2, cfg_data[37*W]);
      end

      // ---- start while busy ----
      for (int p = 0; p < N; p++) cfg_data[p*W +: W] = W'($urandom);
      run_main(1'b1, 1'b0, lc, lw, dn);
      check("busy_start_done_count", dn, 1);
      check("busy_start_rises", rise_cnt, 247);
      check("busy_start_latency", lc, 995);
      check_latched("busy_start_latched", cfg_data);

      // ---- reset in the middle of SHIFT ----
      saved = cfg_data;
      for (int p = 0; p < N; p++) begin
         saved_lat[p] = lat[p];
         cfg_data[p*W +: W] = W'($urandom);
      end
      saved_loads = load_pulses;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      n = 0;
      repeat (2 + 400) begin
         @(negedge clock);
         n++;
      end
      check("midreset_busy_before", busy, 1);
      resetb = 1'b0;
      @(negedge clock);
      check("midreset_outputs", {busy, done, serial_clock, serial_load, serial_data_1, serial_data_2}, 0);
      check("midreset_serial_resetn", serial_resetn, 0);
      @(negedge clock);
      resetb = 1'b1;
      @(negedge clock);
      check("midreset_release_resetn", serial_resetn, 1);
      check("midreset_no_load", load_pulses, saved_loads);
      mism = 0;
      for (int p = 0; p < N; p++) if (lat[p] !== saved_lat[p]) mism++;
      check("midreset_latched_kept", mism, 0);
      check_latched("midreset_latched_is_prev", saved);
      run_main(1'b0, 1'b0, lc, lw, dn);
      check("after_reset_latency", lc, 995);
      check_latched("after_reset_latched", cfg_data);

      // ---- cfg_data change after snapshot ----
      for (int p = 0; p < N; p++) cfg_data[p*W +: W] = W'($urandom);
      saved = cfg_data;
      run_main(1'b0, 1'b1, lc, lw, dn);
      check_latched("snapshot_latched", saved);

      // ---- small unequal-chain instance ----
      for (int p = 0; p < SN1 + SN2; p++) cfg_s[p*W +: W] = W'($urandom) | 13'h1001;
      qs1.delete();
      qs2.delete();
      start_s = 1'b1;
      @(negedge clock);
      start_s = 1'b0;
      n = 0;
      lc = 0;
      while (n < 500) begin
         @(negedge clock);
         n++;
         if (done_s) begin
            lc = n;
            break;
         end
      end
      check("small_latency", lc, 82);
      check("small_bits1", qs1.size(), 39);
      check("small_lead_zeros", sword(1, 0), 0);
      check("small_c1_pad1", sword(1, W), cfg_s[1*W +: W]);
      check("small_c1_pad0", sword(1, 2 * W), cfg_s[0 +: W]);
      check("small_c2_pad2", sword(2, 0), cfg_s[2*W +: W]);
      check("small_c2_pad3", sword(2, W), cfg_s[3*W +: W]);
      check("small_c2_pad4", sword(2, 2 * W), cfg_s[4*W +: W]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
